me_window_server: RTL and testbench
===================================

Name: me_window_server

Overview:
- Responder memory on the read side of the motion-estimation controller's RAM interface.
- Buffers one current macroblock (MACRO_DIM x MACRO_DIM) and one search window (SEARCH_DIM x SEARCH_DIM) of 8-bit luma pixels, loaded row-by-row over a valid/ready stream.
- Answers the controller's per-cycle row/column fetch requests (en_ram, addr, amt, sel, en_cpr, en_spr) with registered pixel vectors for the CPR/SPR arrays.
- Sits between the frame-memory fetch path and the inter-prediction datapath.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels
- SEARCH_DIM, 48, search-window edge in pixels

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start_load  in  1  pulse; begins a load when in IDLE
- load_valid  in  1  load beat valid
- load_ready  out  1  load beat accepted when high with load_valid
- load_row  in  SEARCH_DIM*8  one row, pixel 0 in bits [7:0]; current-MB rows use the low MACRO_DIM*8 bits
- win_ready  out  1  both buffers loaded; drives the controller start qualification
- me_done  in  1  pulse from the controller; releases the buffers
- en_ram  in  1  fetch request strobe
- en_cpr  in  1  request targets the current-MB buffer
- en_spr  in  1  request targets the search-window buffer
- addr  in  6  row index (column mode: top row)
- amt  in  6  horizontal offset of the 16-wide window
- sel  in  2  0/1 = row fetch, 2 = column fetch, 3 = reserved
- rd_data  out  MACRO_DIM*8  fetched pixels, element 0 in bits [7:0]
- rd_valid  out  1  rd_data valid
- oob_err  out  1  sticky out-of-range or illegal-request flag

Behaviour:
- Reset (rst_n low at posedge) values: state IDLE, load_ready 0, win_ready 0, rd_valid 0, rd_data 0, oob_err 0, row counter 0. Buffer contents are undefined after reset.
- FSM states: IDLE, LOAD_CUR, LOAD_SRCH, SERVE.
  - IDLE: start_load -> LOAD_CUR with row counter 0.
  - LOAD_CUR: load_ready=1. Each accepted beat writes cur[cnt] and increments cnt. The beat with cnt==MACRO_DIM-1 -> LOAD_SRCH with cnt=0.
  - LOAD_SRCH: load_ready=1. Each accepted beat writes srch[cnt]. The beat with cnt==SEARCH_DIM-1 -> SERVE.
  - SERVE: win_ready=1, load_ready=0. me_done -> IDLE, clears oob_err. start_load is ignored in SERVE.
- load_valid low stalls the load; the counter holds.
- Fetches are honoured only in SERVE. en_ram outside SERVE is ignored: rd_valid stays 0 and oob_err is unchanged.
- Read latency is 1 cycle. en_ram at cycle N gives rd_valid=1 and rd_data at N+1. rd_valid is 0 otherwise; rd_data holds its last value.
- Back-to-back requests give one result per cycle, with no bubble.
- Fetch modes:
  - en_cpr, sel 0/1: rd_data = cur[addr]. amt is ignored.
  - en_spr, sel 0/1: rd_data[i] = srch[addr][amt+i], i=0..MACRO_DIM-1.
  - en_spr, sel 2: rd_data[i] = srch[addr+i][amt+MACRO_DIM-1] (new right-hand column for the left shift).
- Range checks are done at full 7-bit width, so no wrap-around:
  - cur requests: addr>=MACRO_DIM is out of range.
  - srch row requests: addr>=SEARCH_DIM or amt>SEARCH_DIM-MACRO_DIM is out of range.
  - srch column requests: addr+MACRO_DIM>SEARCH_DIM or amt>SEARCH_DIM-MACRO_DIM is out of range.
- Illegal requests: en_cpr and en_spr both high, both low, or sel==3.
- Out-of-range or illegal request: rd_data=0, rd_valid=1, oob_err set (sticky until me_done or reset).
- me_done and en_ram in the same cycle: the fetch is served (rd_valid next cycle), and the state moves to IDLE.
- Reset mid-load or mid-serve returns to IDLE immediately. The next load overwrites both buffers in full.

Test Plan:
- Load and first fetch: start_load, 16 cur beats (row r = bytes r*16+c), 48 srch beats (byte = r+c) -> win_ready=1 after beat 64. Then en_cpr, addr=5, sel=1 -> next cycle rd_data[0]=80, rd_data[15]=95, rd_valid=1.
- Search row fetch: en_spr, addr=10, amt=7, sel=1 -> rd_data[i]=17+i. Same with sel=0 -> identical data.
- Column fetch: en_spr, addr=3, amt=32, sel=2 -> rd_data[i]=3+i+47; oob_err stays 0.
- Boundaries: amt=32 row fetch -> legal. amt=33 -> rd_data=0, oob_err=1, and the flag stays 1 over later legal fetches until me_done, then 0. addr=33 with sel=2 -> oob.
- Stall, ignore and handshake: toggle load_valid every other cycle -> still exactly 64 accepted beats. en_ram during LOAD_SRCH -> no rd_valid. start_load during SERVE -> no state change.
- Reset: assert rst_n low during LOAD_SRCH at beat 20 -> next cycle all outputs 0 and state IDLE. A full reload then gives correct fetch data.

Source files
------------

// File: rtl/me_window_server_if.sv
// Load stream and fetch request/response bundle between the motion-estimation
// controller (master) and the window buffer server (slave).
interface me_window_server_if #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
);
  logic                    start_load;
  logic                    load_valid;
  logic                    load_ready;
  logic [SEARCH_DIM*8-1:0] load_row;
  logic                    win_ready;
  logic                    me_done;
  logic                    en_ram;
  logic                    en_cpr;
  logic                    en_spr;
  logic [5:0]              addr;
  logic [5:0]              amt;
  logic [1:0]              sel;
  logic [MACRO_DIM*8-1:0]  rd_data;
  logic                    rd_valid;
  logic                    oob_err;

  modport master (
    output start_load, load_valid, load_row, me_done,
           en_ram, en_cpr, en_spr, addr, amt, sel,
    input  load_ready, win_ready, rd_data, rd_valid, oob_err
  );

  modport slave (
    input  start_load, load_valid, load_row, me_done,
           en_ram, en_cpr, en_spr, addr, amt, sel,
    output load_ready, win_ready, rd_data, rd_valid, oob_err
  );
endinterface

// File: rtl/me_window_server.sv
// Current-macroblock and search-window pixel buffer: loaded row by row, then
// serves 16-pixel row/column fetches with one cycle of latency.
module me_window_server #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input logic               clk,
  input logic               rst_n,
  me_window_server_if.slave bus
);

  localparam int MW      = MACRO_DIM * 8;
  localparam int SW      = SEARCH_DIM * 8;
  localparam int CUR_AW  = $clog2(MACRO_DIM);
  localparam int SRCH_AW = $clog2(SEARCH_DIM);
  localparam int AMT_MAX = SEARCH_DIM - MACRO_DIM;

  typedef enum logic [1:0] {IDLE, LOAD_CUR, LOAD_SRCH, SERVE} state_t;

  state_t          state_reg;
  logic [5:0]      cnt_reg;
  logic            load_ready_reg;
  logic            win_ready_reg;
  logic            rd_valid_reg;
  logic            oob_err_reg;
  logic [MW-1:0]   rd_data_reg;

  logic [MW-1:0]   cur_mem  [MACRO_DIM];
  logic [SW-1:0]   srch_mem [SEARCH_DIM];

  logic            beat;
  logic            fire;
  logic            bad_req;
  logic [MW-1:0]   fetch_word;
  logic [MW-1:0]   cur_word;
  logic [MW-1:0]   win_word;
  logic [MW-1:0]   col_word;
  logic [SW-1:0]   srch_word;
  logic [5:0]      col_idx;

  assign beat = bus.load_valid & load_ready_reg;
  assign fire = bus.en_ram & (state_reg == SERVE);

  // Buffer storage carries no reset; a fresh load always rewrites every row.
  always_ff @(posedge clk) begin
    if (beat && state_reg == LOAD_CUR)
      cur_mem[cnt_reg[CUR_AW-1:0]] <= bus.load_row[MW-1:0];
    if (beat && state_reg == LOAD_SRCH)
      srch_mem[cnt_reg[SRCH_AW-1:0]] <= bus.load_row;
  end

  assign cur_word  = cur_mem[bus.addr[CUR_AW-1:0]];
  assign srch_word = srch_mem[SRCH_AW'(bus.addr)];
  assign win_word  = MW'(srch_word >> {bus.amt, 3'b000});
  assign col_idx   = bus.amt + 6'(MACRO_DIM - 1);

  // Column mode gathers one pixel from each of MACRO_DIM consecutive rows.
  for (genvar gi = 0; gi < MACRO_DIM; gi++) begin : g_col
    logic [SRCH_AW-1:0] row_idx;
    assign row_idx = SRCH_AW'(bus.addr + 6'(gi));
    assign col_word[gi*8 +: 8] = 8'(srch_mem[row_idx] >> {col_idx, 3'b000});
  end

  // Range checks run at 7 bits so addr+MACRO_DIM cannot wrap into range.
  always_comb begin
    logic [6:0] addr7;
    logic [6:0] amt7;
    logic       cur_oob;
    logic       row_oob;
    logic       col_oob;
    logic       illegal;
    addr7   = {1'b0, bus.addr};
    amt7    = {1'b0, bus.amt};
    cur_oob = addr7 >= 7'(MACRO_DIM);
    row_oob = (addr7 >= 7'(SEARCH_DIM)) || (amt7 > 7'(AMT_MAX));
    col_oob = ((addr7 + 7'(MACRO_DIM)) > 7'(SEARCH_DIM)) || (amt7 > 7'(AMT_MAX));
    // The current-MB buffer has no column mode, so sel 2 on it is rejected.
    illegal = (bus.en_cpr == bus.en_spr) || (bus.sel == 2'd3) ||
              (bus.en_cpr && bus.sel == 2'd2);
    bad_req    = 1'b0;
    fetch_word = '0;
    if (illegal) begin
      bad_req = 1'b1;
    end else if (bus.en_cpr) begin
      bad_req    = cur_oob;
      fetch_word = cur_word;
    end else if (bus.sel == 2'd2) begin
      bad_req    = col_oob;
      fetch_word = col_word;
    end else begin
      bad_req    = row_oob;
      fetch_word = win_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      load_ready_reg <= 1'b0;
      win_ready_reg  <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      oob_err_reg    <= 1'b0;
    end else begin
      rd_valid_reg <= fire;
      if (fire)
        rd_data_reg <= bad_req ? '0 : fetch_word;

      case (state_reg)
        IDLE: begin
          if (bus.start_load) begin
            state_reg      <= LOAD_CUR;
            cnt_reg        <= '0;
            load_ready_reg <= 1'b1;
          end
        end
        LOAD_CUR: begin
          if (beat) begin
            if (cnt_reg == 6'(MACRO_DIM - 1)) begin
              state_reg <= LOAD_SRCH;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 6'd1;
            end
          end
        end
        LOAD_SRCH: begin
          if (beat) begin
            if (cnt_reg == 6'(SEARCH_DIM - 1)) begin
              state_reg      <= SERVE;
              cnt_reg        <= '0;
              load_ready_reg <= 1'b0;
              win_ready_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 6'd1;
            end
          end
        end
        SERVE: begin
          if (bus.me_done) begin
            state_reg     <= IDLE;
            win_ready_reg <= 1'b0;
            oob_err_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A bad request in the release cycle still leaves the flag raised.
      if (fire && bad_req)
        oob_err_reg <= 1'b1;
    end
  end

  assign bus.load_ready = load_ready_reg;
  assign bus.win_ready  = win_ready_reg;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.rd_data    = rd_data_reg;
  assign bus.oob_err    = oob_err_reg;

endmodule

// File: tb/tb_me_window_server.sv
// Bench for me_window_server: table vectors on a known pattern, hand-written
// corner sequences, and randomized back-to-back fetches against a pixel model.
module tb_me_window_server;

  localparam int MD = 16;
  localparam int SD = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_window_server_if #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) bus ();
  me_window_server #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  byte unsigned cur_m  [MD][MD];
  byte unsigned srch_m [SD][SD];
  bit           oob_m;
  logic [127:0] last_d;

  typedef struct {
    bit          cpr;
    bit          spr;
    int          a;
    int          m;
    int          s;
    byte unsigned lo;
    byte unsigned hi;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected result straight from the pixel arrays; bit 128 flags a rejected request.
  function automatic logic [128:0] model_fetch(bit cpr, bit spr, int a, int m, int s);
    logic [127:0] d = '0;
    bit bad = 0;
    if (cpr == spr || s == 3) bad = 1;
    else if (cpr) begin
      if (s == 2 || a >= MD) bad = 1;
      else for (int i = 0; i < MD; i++) d[i*8 +: 8] = cur_m[a][i];
    end else if (s == 2) begin
      if (a + MD > SD || m > SD - MD) bad = 1;
      else for (int i = 0; i < MD; i++) d[i*8 +: 8] = srch_m[a+i][m+MD-1];
    end else begin
      if (a >= SD || m > SD - MD) bad = 1;
      else for (int i = 0; i < MD; i++) d[i*8 +: 8] = srch_m[a][m+i];
    end
    return {bad, bad ? 128'd0 : d};
  endfunction

  task automatic idle_inputs();
    bus.start_load = 0; bus.load_valid = 0; bus.load_row = '0; bus.me_done = 0;
    bus.en_ram = 0; bus.en_cpr = 0; bus.en_spr = 0; bus.addr = 0; bus.amt = 0; bus.sel = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, bus.load_ready, 0);
    check({tag, "_win_ready"},  bus.win_ready, 0);
    check({tag, "_rd_valid"},   bus.rd_valid, 0);
    check({tag, "_rd_data"},    bus.rd_data, 0);
    check({tag, "_oob_err"},    bus.oob_err, 0);
  endtask

  // mode 0: known pattern, mode 1: random. Returns early once abort_at beats are accepted.
  task automatic load(input int mode, input bit stall, input int abort_at, input bit fetch_during);
    int beats = 0;
    int cyc = 0;
    bit saw_valid = 0;
    bit v;
    logic rdy;
    byte unsigned rowb [SD];
    bus.start_load = 1;
    @(negedge clk);
    bus.start_load = 0;
    while (beats < MD + SD && cyc < 1000) begin
      rdy = bus.load_ready;
      v = stall ? (cyc % 2 == 0) : 1'b1;
      for (int c = 0; c < SD; c++) begin
        if (mode == 0) begin
          if (beats < MD) rowb[c] = (c < MD) ? byte'(beats * 16 + c) : 8'hAA;
          else            rowb[c] = byte'(beats - MD + c);
        end else begin
          rowb[c] = byte'($urandom);
        end
        bus.load_row[c*8 +: 8] = rowb[c];
      end
      bus.load_valid = v;
      if (fetch_during) begin
        bus.en_ram = 1; bus.en_spr = 1; bus.en_cpr = 0; bus.addr = 0; bus.amt = 0; bus.sel = 1;
      end
      @(negedge clk);
      cyc++;
      if (bus.rd_valid) saw_valid = 1;
      if (v && rdy) begin
        for (int c = 0; c < SD; c++) begin
          if (beats < MD) begin
            if (c < MD) cur_m[beats][c] = rowb[c];
          end else begin
            srch_m[beats-MD][c] = rowb[c];
          end
        end
        beats++;
        if (beats == abort_at) begin
          idle_inputs();
          return;
        end
      end
    end
    idle_inputs();
    check("load_beats", beats, MD + SD);
    check("load_win_ready", bus.win_ready, 1);
    check("load_ready_low", bus.load_ready, 0);
    if (fetch_during) check("fetch_during_load", saw_valid, 0);
    oob_m = 0;
  endtask

  task automatic fetch(input string name, input bit cpr, input bit spr, input int a,
                       input int m, input int s, input bit done);
    logic [128:0] e;
    e = model_fetch(cpr, spr, a, m, s);
    bus.en_ram = 1; bus.en_cpr = cpr; bus.en_spr = spr;
    bus.addr = 6'(a); bus.amt = 6'(m); bus.sel = 2'(s); bus.me_done = done;
    @(negedge clk);
    bus.en_ram = 0; bus.me_done = 0;
    if (done) oob_m = 0;
    if (e[128]) oob_m = 1;
    last_d = e[127:0];
    check({name, "_valid"}, bus.rd_valid, 1);
    check({name, "_data"},  bus.rd_data, e[127:0]);
    check({name, "_oob"},   bus.oob_err, oob_m);
  endtask

  task automatic random_serve(input int n);
    bit en, cpr, spr;
    int a, m, s, kind;
    logic [128:0] e;
    for (int k = 0; k < n; k++) begin
      en = ($urandom_range(0, 9) < 8);
      kind = $urandom_range(0, 9);
      if (kind < 3)      begin cpr = 1; spr = 0; end
      else if (kind < 9) begin cpr = 0; spr = 1; end
      else               begin cpr = 1'($urandom); spr = cpr; end
      if (cpr && !spr) s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 1);
      else             s = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 63);
      else if (cpr)   a = $urandom_range(0, MD);
      else if (s == 2) a = $urandom_range(0, SD - MD + 1);
      else            a = $urandom_range(0, SD - 1);
      m = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 63) : $urandom_range(0, SD - MD);
      bus.en_ram = en; bus.en_cpr = cpr; bus.en_spr = spr;
      bus.addr = 6'(a); bus.amt = 6'(m); bus.sel = 2'(s);
      @(negedge clk);
      if (en) begin
        e = model_fetch(cpr, spr, a, m, s);
        last_d = e[127:0];
        if (e[128]) oob_m = 1;
      end
      check("rand_valid", bus.rd_valid, en);
      check("rand_data",  bus.rd_data, last_d);
      check("rand_oob",   bus.oob_err, oob_m);
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0,  5,  0, 1,  80,  95};
    tbl[1] = '{0, 1, 10,  7, 1,  17,  32};
    tbl[2] = '{0, 1, 10,  7, 0,  17,  32};
    tbl[3] = '{0, 1,  3, 32, 2,  50,  65};
    tbl[4] = '{0, 1,  0, 32, 1,  32,  47};
    tbl[5] = '{0, 1, 47,  0, 1,  47,  62};
    tbl[6] = '{0, 1, 32,  0, 2,  47,  62};
    tbl[7] = '{1, 0, 15,  0, 0, 240, 255};
    tbl[8] = '{0, 1, 47, 32, 1,  79,  94};
    tbl[9] = '{1, 0,  0, 40, 1,   0,  15};

    idle_inputs();
    oob_m = 0;
    last_d = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    load(0, 0, -1, 0);
    for (int t = 0; t < 10; t++) begin
      fetch($sformatf("tbl%0d", t), tbl[t].cpr, tbl[t].spr, tbl[t].a, tbl[t].m, tbl[t].s, 0);
      check($sformatf("tbl%0d_lo", t), bus.rd_data[7:0], tbl[t].lo);
      check($sformatf("tbl%0d_hi", t), bus.rd_data[127:120], tbl[t].hi);
    end

    fetch("amt33", 0, 1, 0, 33, 1, 0);
    check("amt33_zero", bus.rd_data, 0);
    check("amt33_flag", bus.oob_err, 1);
    fetch("sticky", 0, 1, 4, 4, 1, 0);
    check("sticky_flag", bus.oob_err, 1);
    fetch("col33", 0, 1, 33, 0, 2, 0);
    check("col33_zero", bus.rd_data, 0);

    bus.start_load = 1;
    @(negedge clk);
    bus.start_load = 0;
    @(negedge clk);
    check("serve_ignore_start_win", bus.win_ready, 1);
    check("serve_ignore_start_ld", bus.load_ready, 0);

    fetch("done_fetch", 1, 0, 2, 0, 1, 1);
    check("done_flag_clear", bus.oob_err, 0);
    check("done_win_ready", bus.win_ready, 0);
    bus.en_ram = 1; bus.en_spr = 1; bus.en_cpr = 0; bus.amt = 40; bus.sel = 1;
    @(negedge clk);
    idle_inputs();
    check("idle_fetch_ignored", bus.rd_valid, 0);
    check("idle_fetch_no_flag", bus.oob_err, 0);

    load(1, 1, -1, 1);
    random_serve(300);

    bus.me_done = 1;
    @(negedge clk);
    bus.me_done = 0;
    load(1, 0, MD + 20, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check_reset_outputs("midload_reset");
    last_d = '0;
    oob_m = 0;
    load(1, 0, -1, 0);
    random_serve(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
